// File: rtl/vga_demo_pkg.sv
// Shared definitions for the VGA demo pixel path.
// Holds default bus widths, the frame tick line, pattern mode encodings
// and the packed animation-control payload latched once per frame.
package vga_demo_pkg;

    localparam int unsigned H_BITS      = 10;
    localparam int unsigned V_BITS      = 10;
    localparam int unsigned FRAME_BITS  = 8;
    localparam int unsigned V_TICK_LINE = 480;

    typedef enum logic [1:0] {
        MODE_PLAID    = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_BARS     = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    // Animation controls as captured on the frame tick
    typedef struct packed {
        mode_e      mode;
        logic [2:0] speed;
        logic       dir;
        logic       pause;
    } ctrl_t;

endpackage

// File: rtl/vga_pattern_lut.sv
// Combinational 2:2:2 colour generator.
// Ports: mx (scrolled x), vpos (beam y), mode (pattern select),
//        frame_count (frame counter) -> r_c/g_c/b_c colour channels.
module vga_pattern_lut
    import vga_demo_pkg::*;
#(
    parameter int unsigned H_BITS     = vga_demo_pkg::H_BITS,
    parameter int unsigned V_BITS     = vga_demo_pkg::V_BITS,
    parameter int unsigned FRAME_BITS = vga_demo_pkg::FRAME_BITS
) (
    input  logic [H_BITS-1:0]     mx,
    input  logic [V_BITS-1:0]     vpos,
    input  mode_e                 mode,
    input  logic [FRAME_BITS-1:0] frame_count,
    output logic [1:0]            r_c,
    output logic [1:0]            g_c,
    output logic [1:0]            b_c
);

    logic checker_c;
    logic unused_bits_c;

    assign checker_c = mx[5] ^ vpos[5];

    // Bits that no pattern looks at
    assign unused_bits_c = ^{mx[H_BITS-1:9], mx[4:0], vpos[V_BITS-1:9],
                             vpos[6], vpos[4:3], vpos[1:0], frame_count[5:0]};

    // Pattern select
    always_comb begin
        r_c = 2'b00;
        g_c = 2'b00;
        b_c = 2'b00;
        unique case (mode)
            MODE_PLAID: begin
                r_c = {mx[5], vpos[2]};
                g_c = {mx[6], vpos[2]};
                b_c = {mx[7], vpos[5]};
            end
            MODE_CHECKER: begin
                r_c = {checker_c, checker_c};
                g_c = {checker_c, checker_c};
                b_c = {checker_c, checker_c};
            end
            MODE_BARS: begin
                r_c = mx[8:7];
                g_c = mx[7:6];
                b_c = mx[6:5];
            end
            MODE_GRADIENT: begin
                r_c = vpos[8:7];
                g_c = mx[8:7];
                b_c = frame_count[7:6];
            end
            default: begin
                r_c = 2'b00;
                g_c = 2'b00;
                b_c = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/vga_scroll_pattern.sv
// Scrolling pattern colour stage between VGA timing and the PMOD pins.
// Inputs: clk, rst_n, hpos/vpos/display_on/hsync_in/vsync_in from the timing
//         generator, mode/speed/dir/pause animation controls.
// Outputs: registered r/g/b_out, hsync_out/vsync_out/de_out (1 clk delay),
//          frame_count and scroll_offset.
// Controls are sampled only on the frame tick so a frame never tears.
module vga_scroll_pattern
    import vga_demo_pkg::*;
#(
    parameter int unsigned H_BITS      = vga_demo_pkg::H_BITS,
    parameter int unsigned V_BITS      = vga_demo_pkg::V_BITS,
    parameter int unsigned FRAME_BITS  = vga_demo_pkg::FRAME_BITS,
    parameter int unsigned V_TICK_LINE = vga_demo_pkg::V_TICK_LINE,
    parameter logic        SYNC_RESET  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [H_BITS-1:0]     hpos,
    input  logic [V_BITS-1:0]     vpos,
    input  logic                  display_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [1:0]            mode,
    input  logic [2:0]            speed,
    input  logic                  dir,
    input  logic                  pause,
    output logic [1:0]            r_out,
    output logic [1:0]            g_out,
    output logic [1:0]            b_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out,
    output logic [FRAME_BITS-1:0] frame_count,
    output logic [H_BITS-1:0]     scroll_offset
);

    ctrl_t             ctrl_q;
    logic [H_BITS-1:0] offset_q;
    logic              tick_c;
    logic [H_BITS-1:0] mx_c;
    logic [1:0]        r_c;
    logic [1:0]        g_c;
    logic [1:0]        b_c;
    logic              unused_ctrl_c;

    // One-cycle frame tick at the start of the first blanking line
    assign tick_c = (hpos == '0) && (vpos == V_BITS'(V_TICK_LINE));

    // Scrolled x uses the offset held this cycle (pre-update on the tick)
    assign mx_c = hpos + offset_q;

    // Only the mode drives the pattern; the rest are kept for visibility
    assign unused_ctrl_c = ^{ctrl_q.speed, ctrl_q.dir, ctrl_q.pause};

    assign scroll_offset = offset_q;

    vga_pattern_lut #(
        .H_BITS     (H_BITS),
        .V_BITS     (V_BITS),
        .FRAME_BITS (FRAME_BITS)
    ) u_lut (
        .mx          (mx_c),
        .vpos        (vpos),
        .mode        (ctrl_q.mode),
        .frame_count (frame_count),
        .r_c         (r_c),
        .g_c         (g_c),
        .b_c         (b_c)
    );

    // Per-frame state: control latch, scroll offset, frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            offset_q    <= '0;
            frame_count <= '0;
        end else if (tick_c) begin
            ctrl_q      <= '{mode: mode_e'(mode), speed: speed, dir: dir, pause: pause};
            frame_count <= frame_count + FRAME_BITS'(1);
            if (!pause) begin
                if (dir) offset_q <= offset_q - H_BITS'(speed);
                else     offset_q <= offset_q + H_BITS'(speed);
            end
        end
    end

    // Output stage keeps colour and syncs aligned at the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= 2'b00;
            g_out     <= 2'b00;
            b_out     <= 2'b00;
            hsync_out <= SYNC_RESET;
            vsync_out <= SYNC_RESET;
            de_out    <= 1'b0;
        end else begin
            r_out     <= display_on ? r_c : 2'b00;
            g_out     <= display_on ? g_c : 2'b00;
            b_out     <= display_on ? b_c : 2'b00;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            de_out    <= display_on;
        end
    end

endmodule
